stack_sequencer: RTL and testbench

Multi-cycle stack engine for the 16-bit multicycle datapath. It owns the stack pointer and turns single-handshake PUSH/POP/PEEK/SWAP commands from the control unit into byte-addressed, word-aligned data-memory transactions. It acts as the initiator on the memory port: it drives address, write data and write/read strobes, and consumes the memory block's read data.

---
 rtl/stack_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_stack_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// Stack engine: owns the stack pointer and turns PUSH/POP/PEEK/SWAP commands
// into word-aligned memory transactions on a registered initiator port.
module stack_sequencer #(
  parameter logic [15:0] SP_TOP = 16'h0FFE,
  parameter int          DEPTH  = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic [15:0] sp_out,
  output logic [6:0]  depth
);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH_WR, S_RD1, S_RD2, S_CAP, S_SW_WR1, S_SW_WR2, S_RESP, S_ERR
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b11;
  localparam logic [6:0] DEPTH_MAX = 7'(DEPTH);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] sp_q, sp_d;
  logic [6:0]  depth_q, depth_d;
  logic [15:0] top_q, top_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        err_ov_q, err_ov_d;
  logic        err_un_q, err_un_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        accept;

  assign accept = cmd_valid && (state_q == S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_PUSH;
      sp_q        <= SP_TOP;
      depth_q     <= '0;
      top_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      err_ov_q    <= 1'b0;
      err_un_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sp_q        <= sp_d;
      depth_q     <= depth_d;
      top_q       <= top_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_ov_q    <= err_ov_d;
      err_un_q    <= err_un_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUSH: state_d = (depth_q == DEPTH_MAX) ? S_ERR : S_PUSH_WR;
            OP_SWAP: state_d = (depth_q < 7'd2)       ? S_ERR : S_RD1;
            default: state_d = (depth_q == 7'd0)      ? S_ERR : S_RD1;
          endcase
        end
      end
      S_PUSH_WR: state_d = S_IDLE;
      S_RD1:     state_d = (op_q == OP_SWAP) ? S_RD2 : S_CAP;
      S_RD2:     state_d = S_CAP;
      S_CAP:     state_d = (op_q == OP_SWAP) ? S_SW_WR1 : S_RESP;
      S_SW_WR1:  state_d = S_SW_WR2;
      S_SW_WR2:  state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered so they appear registered
  // in that state; captures and pointer updates happen on leaving a state.
  always_comb begin
    op_d        = op_q;
    sp_d        = sp_q;
    depth_d     = depth_q;
    top_d       = top_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    err_ov_d    = 1'b0;
    err_un_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;

    case (state_q)
      S_IDLE:    if (accept) op_d = cmd_op;
      S_PUSH_WR: begin
        sp_d    = sp_q - 16'd2;
        depth_d = depth_q + 7'd1;
      end
      S_RD2:     top_d = mem_rdata;
      S_CAP: begin
        rsp_data_d = mem_rdata;
        if (op_q == OP_POP) begin
          sp_d    = sp_q + 16'd2;
          depth_d = depth_q - 7'd1;
        end
      end
      default: ;
    endcase

    case (state_d)
      S_PUSH_WR: begin
        we_d    = 1'b1;
        addr_d  = sp_q;
        wdata_d = cmd_data;
      end
      S_RD1: begin
        re_d   = 1'b1;
        addr_d = sp_q + 16'd2;
      end
      S_RD2: begin
        re_d   = 1'b1;
        addr_d = sp_q + 16'd4;
      end
      S_SW_WR1: begin
        we_d    = 1'b1;
        addr_d  = sp_q + 16'd2;
        wdata_d = mem_rdata;
      end
      S_SW_WR2: begin
        we_d    = 1'b1;
        addr_d  = sp_q + 16'd4;
        wdata_d = top_q;
      end
      S_RESP: rsp_valid_d = 1'b1;
      S_ERR: begin
        err_ov_d = (cmd_op == OP_PUSH);
        err_un_d = (cmd_op != OP_PUSH);
      end
      default: ;
    endcase
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_we        = we_q;
  assign mem_re        = re_q;
  assign sp_out        = sp_q;
  assign depth         = depth_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: command table checked cycle by cycle
// against hand-computed strobes, responses and pointer values.
module tb_stack_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        err_overflow, err_underflow;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] sp_out;
  logic [6:0]  depth;

  stack_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .sp_out(sp_out), .depth(depth)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:4095];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[12:1]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[12:1]];
  end

  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, PEEK = 2'b10, SWAP = 2'b11;
  localparam logic [1:0] E_NONE = 2'd0, E_OVF = 2'd1, E_UNF = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [1:0]  err;
    logic [15:0] rsp;   // POP/PEEK value, or new top (old next) for SWAP
    logic [15:0] aux;   // SWAP only: old top
    logic [15:0] sp;
    logic [6:0]  dep;
  } vec_t;

  vec_t        vecs [0:127];
  int          nvec = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] sp_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [15:0] data, input logic [1:0] err,
                     input logic [15:0] rsp, input logic [15:0] aux,
                     input logic [15:0] sp, input logic [6:0] dep);
    vecs[nvec] = '{op, data, err, rsp, aux, sp, dep};
    nvec++;
  endtask

  // Issues one command at a negedge and checks every cycle until cmd_ready returns.
  task automatic run_cmd(input vec_t v, input logic [15:0] sp0, input int idx);
    int waitc;
    int len;
    logic exp_we, exp_re, exp_rv, exp_eo, exp_eu;
    logic [15:0] exp_addr, exp_wd;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    if (!cmd_ready) begin
      chk($sformatf("v%0d ready_timeout", idx), 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    if (v.err != E_NONE)   len = 2;
    else if (v.op == PUSH) len = 2;
    else if (v.op == SWAP) len = 7;
    else                   len = 4;
    for (int k = 1; k <= len; k++) begin
      @(negedge clock);
      if (k == 1) cmd_valid = 1'b0;
      exp_we = 0; exp_re = 0; exp_rv = 0; exp_eo = 0; exp_eu = 0;
      exp_addr = 16'h0; exp_wd = 16'h0;
      if (v.err != E_NONE) begin
        if (k == 1) begin
          exp_eo = (v.err == E_OVF);
          exp_eu = (v.err == E_UNF);
        end
      end else begin
        case (v.op)
          PUSH: if (k == 1) begin exp_we = 1; exp_addr = sp0; exp_wd = v.data; end
          SWAP: case (k)
            1: begin exp_re = 1; exp_addr = sp0 + 16'd2; end
            2: begin exp_re = 1; exp_addr = sp0 + 16'd4; end
            4: begin exp_we = 1; exp_addr = sp0 + 16'd2; exp_wd = v.rsp; end
            5: begin exp_we = 1; exp_addr = sp0 + 16'd4; exp_wd = v.aux; end
            6: exp_rv = 1;
            default: ;
          endcase
          default: begin
            if (k == 1) begin exp_re = 1; exp_addr = sp0 + 16'd2; end
            if (k == 3) exp_rv = 1;
          end
        endcase
      end
      chk($sformatf("v%0d A+%0d rdy/we/re/rv/eo/eu", idx, k),
          32'({cmd_ready, mem_we, mem_re, rsp_valid, err_overflow, err_underflow}),
          32'({(k == len), exp_we, exp_re, exp_rv, exp_eo, exp_eu}));
      if (exp_we || exp_re) chk($sformatf("v%0d A+%0d mem_addr", idx, k), 32'(mem_addr), 32'(exp_addr));
      if (exp_we) chk($sformatf("v%0d A+%0d mem_wdata", idx, k), 32'(mem_wdata), 32'(exp_wd));
      if (exp_rv) chk($sformatf("v%0d A+%0d rsp_data", idx, k), 32'(rsp_data), 32'(v.rsp));
    end
    chk($sformatf("v%0d sp_out", idx), 32'(sp_out), 32'(v.sp));
    chk($sformatf("v%0d depth", idx), 32'(depth), 32'(v.dep));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    sp_cur = 16'h0FFE;
  endtask

  vec_t hv;

  initial begin
    // PUSH 0..15 then POP x16
    for (int i = 0; i < 16; i++)
      add(PUSH, 16'(i), E_NONE, 16'h0, 16'h0, 16'h0FFE - 16'(2 * (i + 1)), 7'(i + 1));
    for (int j = 0; j < 16; j++)
      add(POP, 16'h0, E_NONE, 16'(15 - j), 16'h0, 16'h0FDE + 16'(2 * (j + 1)), 7'(15 - j));
    // underflow cases
    add(POP,  16'h0, E_UNF, 16'h0, 16'h0, 16'h0FFE, 7'd0);
    add(PEEK, 16'h0, E_UNF, 16'h0, 16'h0, 16'h0FFE, 7'd0);
    add(SWAP, 16'h0, E_UNF, 16'h0, 16'h0, 16'h0FFE, 7'd0);
    add(PUSH, 16'h0007, E_NONE, 16'h0, 16'h0, 16'h0FFC, 7'd1);
    add(SWAP, 16'h0, E_UNF, 16'h0, 16'h0, 16'h0FFC, 7'd1);
    add(POP,  16'h0, E_NONE, 16'h0007, 16'h0, 16'h0FFE, 7'd0);
    // PEEK / SWAP / POP ordering
    add(PUSH, 16'hAAAA, E_NONE, 16'h0, 16'h0, 16'h0FFC, 7'd1);
    add(PUSH, 16'h5555, E_NONE, 16'h0, 16'h0, 16'h0FFA, 7'd2);
    add(PEEK, 16'h0, E_NONE, 16'h5555, 16'h0, 16'h0FFA, 7'd2);
    add(SWAP, 16'h0, E_NONE, 16'hAAAA, 16'h5555, 16'h0FFA, 7'd2);
    add(POP,  16'h0, E_NONE, 16'hAAAA, 16'h0, 16'h0FFC, 7'd1);
    add(POP,  16'h0, E_NONE, 16'h5555, 16'h0, 16'h0FFE, 7'd0);
    // fill to DEPTH then overflow
    for (int i = 0; i < 64; i++)
      add(PUSH, 16'h0100 + 16'(i), E_NONE, 16'h0, 16'h0, 16'h0FFE - 16'(2 * (i + 1)), 7'(i + 1));
    add(PUSH, 16'hBEEF, E_OVF, 16'h0, 16'h0, 16'h0F7E, 7'd64);
    add(PEEK, 16'h0, E_NONE, 16'h013F, 16'h0, 16'h0F7E, 7'd64);

    // reset values, checked during and after reset
    reset_n = 1'b0;
    #12;
    chk("rst_in sp_out", 32'(sp_out), 32'h0FFE);
    chk("rst_in strobes", 32'({mem_we, mem_re, rsp_valid, err_overflow, err_underflow}), 32'd0);
    apply_reset();
    chk("rst sp_out", 32'(sp_out), 32'h0FFE);
    chk("rst depth", 32'(depth), 32'd0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst strobes", 32'({mem_we, mem_re, rsp_valid, err_overflow, err_underflow}), 32'd0);
    chk("rst data regs", {rsp_data, mem_addr}, 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);

    for (int i = 0; i < nvec; i++) begin
      run_cmd(vecs[i], sp_cur, i);
      sp_cur = vecs[i].sp;
    end

    // reset asserted during SW_WR1
    apply_reset();
    hv = '{PUSH, 16'hAAAA, E_NONE, 16'h0, 16'h0, 16'h0FFC, 7'd1};
    run_cmd(hv, sp_cur, 200);
    hv = '{PUSH, 16'h5555, E_NONE, 16'h0, 16'h0, 16'h0FFA, 7'd2};
    run_cmd(hv, 16'h0FFC, 201);
    cmd_valid = 1'b1;
    cmd_op    = SWAP;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("swrst A+4 mem_we", 32'(mem_we), 32'd1);
    chk("swrst A+4 mem_addr", 32'(mem_addr), 32'h0FFC);
    reset_n = 1'b0;
    #1;
    chk("swrst async mem_we", 32'(mem_we), 32'd0);
    chk("swrst async sp_out", 32'(sp_out), 32'h0FFE);
    chk("swrst async depth", 32'(depth), 32'd0);
    @(negedge clock);
    chk("swrst A+5 strobes", 32'({mem_we, mem_re}), 32'd0);
    chk("swrst A+5 ready", 32'(cmd_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);
    hv = '{PUSH, 16'h1234, E_NONE, 16'h0, 16'h0, 16'h0FFC, 7'd1};
    run_cmd(hv, 16'h0FFE, 202);
    hv = '{PEEK, 16'h0, E_NONE, 16'h1234, 16'h0, 16'h0FFC, 7'd1};
    run_cmd(hv, 16'h0FFC, 203);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
